// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory wait.
// Optional stall-cycle counter is built only when STALL_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic [1:0]       state
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1
  } state_t;

  state_t state_reg, state_next;
  logic   br_pend_reg, br_pend_next;
  logic [4:0] rs_eq, rt_eq;
  logic   load_use;
  logic   flush_now;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_opmatch
      assign rs_eq[gi] = ~(idex_rt[gi] ^ ifid_rs[gi]);
      assign rt_eq[gi] = ~(idex_rt[gi] ^ ifid_rt[gi]);
    end
  endgenerate

  assign load_use = idex_memread && (idex_rt != 5'd0) && ((&rs_eq) || (&rt_eq));

  // A branch resolved during a memory wait is replayed as a flush on exit.
  assign flush_now = branch_taken || ((state_reg == MWAIT) && br_pend_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= RUN;
      br_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      br_pend_reg <= br_pend_next;
    end
  end

  always_comb begin
    state_next   = RUN;
    br_pend_next = 1'b0;
    if (mem_busy) begin
      state_next   = MWAIT;
      br_pend_next = br_pend_reg || branch_taken;
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b1;
    if (!reset) begin
      if (mem_busy) begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        exmem_we = 1'b0;
      end else if (flush_now) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  assign state = state_reg;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (!pc_we && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic.
// Expected strobes come from a cycle-level model of the hazard priority rules.
module tb_pipe_hazard_ctrl;
  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       idex_memread, branch_taken, mem_busy;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we;
  logic [1:0] state;
`ifdef STALL_CNT_EN
  logic [TB_CNT_W-1:0] stall_count;
`endif

  pipe_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .idex_rt      (idex_rt),
    .idex_memread (idex_memread),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_we     (exmem_we),
    .state        (state)
`ifdef STALL_CNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Strobe vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we}
  typedef struct {
    int         cyc;
    logic [4:0] strobes;
    int         st;
    int         cnt;
  } exp_t;

  typedef enum {EV_GO, EV_STALL, EV_FLUSH, EV_HOLD} ev_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Model of the pipeline's view: waiting on memory, a branch owed, stalls so far.
  bit m_wait = 0;
  bit m_owed = 0;
  int m_cnt  = 0;

  task automatic check(input string name, input int cy, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cy, act, req);
  endtask

  function automatic ev_t classify(input bit mb, input bit br, input bit mr,
                                   input int irt, input int rs, input int rt);
    bit lu;
    lu = mr && irt != 0 && (irt == rs || irt == rt);
    if (mb) return EV_HOLD;
    if (br || (m_wait && m_owed)) return EV_FLUSH;
    if (lu) return EV_STALL;
    return EV_GO;
  endfunction

  task automatic step(input bit rst, input bit mb, input bit br, input bit mr,
                      input int irt, input int rs, input int rt);
    exp_t e;
    ev_t  ev;
    bit   was_reset;
    was_reset    = reset;
    reset        = rst;
    mem_busy     = mb;
    branch_taken = br;
    idex_memread = mr;
    idex_rt      = irt[4:0];
    ifid_rs      = rs[4:0];
    ifid_rt      = rt[4:0];
    if (rst) begin
      m_wait = 0;
      m_owed = 0;
      m_cnt  = 0;
    end
    ev = classify(mb, br, mr, irt, rs, rt);
    e.cyc = cyc;
    e.st  = m_wait ? 1 : 0;
    e.cnt = m_cnt;
    if (rst) e.strobes = 5'b11001;
    else case (ev)
      EV_HOLD:  e.strobes = 5'b00000;
      EV_FLUSH: e.strobes = 5'b11111;
      EV_STALL: e.strobes = 5'b00011;
      default:  e.strobes = 5'b11001;
    endcase
    exp_q.push_back(e);
    if (rst && !was_reset) begin
      #1;
      check("async_reset_state", cyc, int'(state), 0);
`ifdef STALL_CNT_EN
      check("async_reset_count", cyc, int'(stall_count), 0);
`endif
    end
    @(posedge clock);
    #1;
    cyc++;
    if (!rst) begin
      if ((ev == EV_HOLD || ev == EV_STALL) && m_cnt < CNT_MAX) m_cnt++;
      m_owed = mb ? (m_owed || br) : 1'b0;
      m_wait = mb;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobes", e.cyc, int'({pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we}),
              int'(e.strobes));
        check("state", e.cyc, int'(state), e.st);
`ifdef STALL_CNT_EN
        check("stall_count", e.cyc, int'(stall_count), e.cnt);
`endif
        $display("cycle %0d strobes=%b state=%0d", e.cyc,
                 {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we}, state);
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; mem_busy = 0; branch_taken = 0; idex_memread = 0;
    idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    @(posedge clock);
    #1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 3, 3, 3);
    // single load-use stall, then normal flow after the bubble
    step(0, 0, 0, 1, 5, 5, 9);
    step(0, 0, 0, 0, 5, 5, 9);
    // $zero destination never stalls
    step(0, 0, 0, 1, 0, 7, 0);
    // branch beats load-use
    step(0, 0, 1, 1, 5, 5, 0);
    // three-cycle memory wait with a branch in the middle, then one flush
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // reset in the second wait cycle drops the owed flush
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // five consecutive stalls saturate the narrow counter
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1),
           $urandom_range(0, 3),
           $urandom_range(0, 3),
           $urandom_range(0, 3));
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", cyc, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-002 SHALL have ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- ifid_rs  in  5  IF/ID instr[25:21]
- ifid_rt  in  5  IF/ID instr[20:16]
- idex_rt  in  5  ID/EX instrout_2016
- idex_memread  in  1  ID/EX MemRead control bit
- branch_taken  in  1  EX-stage taken branch/jump
- mem_busy  in  1  data memory not ready
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID load NOP
- idex_bubble  out  1  force ID/EX CTR_bits to 0
- exmem_we  out  1  EX/MEM and MEM/WB write enable
- state  out  2  FSM state: 0 RUN, 1 MWAIT
- stall_count  out  CNT_W  stall-cycle counter (STALL_CNT_EN only)

Function
REQ-003 SHALL run a 2-state FSM (RUN, MWAIT); state register only; all strobe outputs combinational from state and inputs.
REQ-004 SHALL define load_use = idex_memread AND idex_rt != 0 AND (idex_rt == ifid_rs OR idex_rt == ifid_rt).
REQ-005 SHALL give priority mem_busy > branch_taken > load_use within a cycle.
REQ-006 In RUN with no event: pc_we=ifid_we=exmem_we=1, ifid_flush=idex_bubble=0.
REQ-007 In RUN with load_use only: pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=1, ifid_flush=0; stay RUN.
REQ-008 In RUN with branch_taken (no mem_busy): pc_we=1, ifid_flush=1, idex_bubble=1, exmem_we=1, load_use ignored; stay RUN.
REQ-009 In RUN or MWAIT with mem_busy=1: pc_we=ifid_we=exmem_we=0, ifid_flush=idex_bubble=0; next state MWAIT.
REQ-010 Branch_taken seen while mem_busy=1 SHALL set flag br_pend; multiple assertions coalesce into one.
REQ-011 In MWAIT with mem_busy=0: next state RUN; outputs as RUN, except br_pend=1 forces REQ-008 outputs that cycle and clears br_pend.
REQ-012 Stall cycle = any cycle with pc_we=0; back-to-back load_use with unchanged operands SHALL not occur since the bubble clears idex_memread.

Reset
REQ-013 Reset SHALL force state=RUN, br_pend=0, stall_count=0 immediately, regardless of clock.
REQ-014 During reset outputs SHALL be pc_we=ifid_we=exmem_we=1, ifid_flush=0, idex_bubble=0.
REQ-015 Reset mid-MWAIT SHALL drop any pending flush; first post-reset edge evaluates as RUN.

Configuration
REQ-016 Macro STALL_CNT_EN defined: stall_count increments by 1 per stall cycle, saturates at 2^CNT_W-1, no wrap.
REQ-017 STALL_CNT_EN undefined: no stall_count port and no counter logic; all other behaviour identical.

Verification
REQ-018 idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle normal after bubble.
REQ-019 idex_memread=1, idex_rt=0, ifid_rt=0 -> no stall, all enables 1.
REQ-020 branch_taken=1 coincident with load_use -> ifid_flush=1, idex_bubble=1, pc_we=1, stall_count unchanged.
REQ-021 mem_busy=1 for 3 cycles with branch_taken pulse in cycle 2 -> state=1, enables 0 for 3 cycles, stall_count=3, then one cycle ifid_flush=1, idex_bubble=1.
REQ-022 Reset asserted in 2nd MWAIT cycle -> state=0, stall_count=0 without clock edge; no flush after release.
REQ-023 CNT_W=2, 5 consecutive stall cycles -> stall_count holds 3.
